dmem_bridge: RTL and testbench
==============================

DMEM_BRIDGE -- requirements
Module: dmem_bridge

Interface
REQ-001 Parameter MAP_KSEG, default 1, meaning: when 1, addresses with addr[31:29]=3'b100 or 3'b101 have bits [31:29] cleared on bus_addr.
REQ-002 clk  in  1  single clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset; asynchronous, active-low.
REQ-004 mem_en  in  1  memory access request from the M stage.
REQ-005 mem_wen  in  4  byte-write enables (0000 = load).
REQ-006 mem_size  in  2  access size: 0 byte, 1 half, 2 word.
REQ-007 mem_addr, mem_wdata  in  32 each  M-stage address and aligned write data.
REQ-008 mem_cancel  in  1  M-stage exception or flush for the current instruction.
REQ-009 pipe_stall  in  1  pipeline stalled by another source (e.g. divider).
REQ-010 mem_rdata  out  32  load data returned to the M stage.
REQ-011 mem_stall  out  1  hold-pipeline request.
REQ-012 bus_req, bus_wr  out  1 each  bus request and write flag.
REQ-013 bus_size  out  2; bus_addr, bus_wdata  out  32 each.
REQ-014 bus_addr_ok, bus_data_ok  in  1 each; bus_rdata  in  32.

Function
REQ-015 The FSM SHALL have the states IDLE, REQ, WAIT and DONE, plus a 1-bit discard flag.
REQ-016 IDLE: when mem_en=1 and mem_cancel=0, the block SHALL latch addr (mapped), wdata, size and wr=|mem_wen, and go to REQ next cycle.
REQ-017 REQ: bus_req SHALL be 1 with the latched fields held stable; on bus_addr_ok=1 the FSM SHALL go to WAIT.
REQ-018 WAIT: on bus_data_ok=1, the block SHALL register bus_rdata into mem_rdata (loads only) and go to DONE, or to IDLE if discard=1.
REQ-019 DONE: the block SHALL stay in DONE while pipe_stall=1 with mem_rdata held, and go to IDLE when pipe_stall=0.
REQ-020 mem_stall SHALL equal mem_en & ~mem_cancel & (state != DONE), combinationally; it SHALL also be 1 in any state while discard=1 and mem_en=1.
REQ-021 bus_data_ok SHALL be ignored outside WAIT; bus_addr_ok SHALL be ignored outside REQ.
REQ-022 Minimum latency: mem_en at cycle 0, bus_req at cycle 1, addr_ok at cycle 1, data_ok at cycle 2, DONE at cycle 3 with mem_stall=0.
REQ-023 mem_cancel in IDLE SHALL suppress the request; mem_cancel in REQ without addr_ok SHALL drop bus_req next cycle and return to IDLE.
REQ-024 mem_cancel in REQ with addr_ok in the same cycle, or in WAIT, SHALL set discard; the outstanding data_ok SHALL then be consumed without updating mem_rdata.
REQ-025 A new request SHALL NOT be issued until any discarded transaction completes (at most one outstanding).
REQ-026 mem_cancel in DONE SHALL return the FSM to IDLE next cycle.
REQ-027 Addresses outside kseg0/kseg1, or any address with MAP_KSEG=0, SHALL pass through unchanged.

Reset
REQ-028 While rst=0: state IDLE, discard 0, bus_req 0, bus_wr 0, bus_size 0, bus_addr 0, bus_wdata 0, mem_rdata 0; mem_stall SHALL be 0.
REQ-029 Reset asserted mid-transaction SHALL abandon it immediately; no bus output SHALL remain asserted.

Structure
REQ-030 The FSM state encoding, size codes and the kseg mapping function SHALL live in the shared package mips_bus_pkg.
REQ-031 The block SHALL be a single module with no sub-modules; registered outputs SHALL be driven from state and latches only.

Verification
REQ-032 Word load at 0xBFC0_0100, addr_ok at cycle 1, data_ok at cycle 2 with rdata 0x1234_5678 -> bus_addr 0x1FC0_0100, bus_wr 0, mem_stall low at cycle 3, mem_rdata 0x1234_5678.
REQ-033 Byte store (wen 0010, addr 0x8000_0011, wdata 0x0000_AB00) with addr_ok delayed 4 cycles -> bus_req held 5 cycles with stable fields, bus_size 0, bus_wr 1, bus_addr 0x0000_0011.
REQ-034 Load completes while pipe_stall=1 for 3 cycles -> state held in DONE, no second bus_req, mem_rdata stable, return to IDLE after pipe_stall falls.
REQ-035 mem_cancel asserted in WAIT, then a new load issued -> first data_ok (0xDEAD_BEEF) is discarded, mem_rdata unchanged, second bus_req appears only after that data_ok.
REQ-036 rst pulled low during REQ -> all bus outputs 0 asynchronously; after release, mem_en starts a fresh transaction.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// Shared definitions for the M-stage data memory bridge: FSM state encoding,
// bus size codes and the kseg0/kseg1 address mapping.
package mips_bus_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StWait = 2'd2,
        StDone = 2'd3
    } bus_state_e;

    localparam logic [1:0] SizeByte = 2'd0;
    localparam logic [1:0] SizeHalf = 2'd1;
    localparam logic [1:0] SizeWord = 2'd2;

    // kseg0 (100) and kseg1 (101) alias physical memory from address 0.
    function automatic logic [31:0] map_kseg(input logic [31:0] addr, input logic enable);
        logic [31:0] mapped;
        mapped = addr;
        if (enable && (addr[31:29] == 3'b100 || addr[31:29] == 3'b101)) begin
            mapped[31:29] = 3'b000;
        end
        return mapped;
    endfunction

endpackage

// File: rtl/dmem_bridge.sv
// Bridges M-stage load/store requests onto a split address/data handshake bus.
// At most one bus transaction is outstanding; a cancelled transaction whose
// address phase was already accepted is drained silently before the next one.
module dmem_bridge
    import mips_bus_pkg::*;
#(
    parameter bit MAP_KSEG = 1'b1
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic        mem_en_i,
    input  logic [3:0]  mem_wen_i,
    input  logic [1:0]  mem_size_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_cancel_i,
    input  logic        pipe_stall_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stall_o,

    output logic        bus_req_o,
    output logic        bus_wr_o,
    output logic [1:0]  bus_size_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    input  logic        bus_addr_ok_i,
    input  logic        bus_data_ok_i,
    input  logic [31:0] bus_rdata_i
);

    bus_state_e  state_q;
    logic        discard_q;
    logic        bus_req_q;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;

    // Transaction FSM together with the latched request fields and load data.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            discard_q <= 1'b0;
            bus_req_q <= 1'b0;
            wr_q      <= 1'b0;
            size_q    <= SizeByte;
            addr_q    <= 32'h0;
            wdata_q   <= 32'h0;
            rdata_q   <= 32'h0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (mem_en_i && !mem_cancel_i) begin
                        addr_q    <= map_kseg(mem_addr_i, MAP_KSEG);
                        wdata_q   <= mem_wdata_i;
                        size_q    <= mem_size_i;
                        wr_q      <= |mem_wen_i;
                        bus_req_q <= 1'b1;
                        state_q   <= StReq;
                    end
                end
                StReq: begin
                    if (bus_addr_ok_i) begin
                        // Address accepted: the data phase must be consumed even if cancelled.
                        bus_req_q <= 1'b0;
                        discard_q <= mem_cancel_i;
                        state_q   <= StWait;
                    end else if (mem_cancel_i) begin
                        bus_req_q <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StWait: begin
                    if (bus_data_ok_i) begin
                        discard_q <= 1'b0;
                        if (discard_q || mem_cancel_i) begin
                            state_q <= StIdle;
                        end else begin
                            if (!wr_q) begin
                                rdata_q <= bus_rdata_i;
                            end
                            state_q <= StDone;
                        end
                    end else if (mem_cancel_i) begin
                        discard_q <= 1'b1;
                    end
                end
                StDone: begin
                    // Hold the result until the pipeline actually advances.
                    if (mem_cancel_i || !pipe_stall_i) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Hold the pipeline until the access completes, or while a drained access is pending.
    always_comb begin
        mem_stall_o = 1'b0;
        if (rst_ni && mem_en_i) begin
            mem_stall_o = (!mem_cancel_i && (state_q != StDone)) || discard_q;
        end
    end

    assign bus_req_o   = bus_req_q;
    assign bus_wr_o    = wr_q;
    assign bus_size_o  = size_q;
    assign bus_addr_o  = addr_q;
    assign bus_wdata_o = wdata_q;
    assign mem_rdata_o = rdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: expected bus transactions and load
// results are queued at issue time and compared when the DUT presents them.
module tb_dmem_bridge;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        mem_en_i = 1'b0;
    logic [3:0]  mem_wen_i = 4'h0;
    logic [1:0]  mem_size_i = 2'd0;
    logic [31:0] mem_addr_i = 32'h0;
    logic [31:0] mem_wdata_i = 32'h0;
    logic        mem_cancel_i = 1'b0;
    logic        pipe_stall_i = 1'b0;
    logic [31:0] mem_rdata_o;
    logic        mem_stall_o;
    logic        bus_req_o;
    logic        bus_wr_o;
    logic [1:0]  bus_size_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_addr_ok_i = 1'b0;
    logic        bus_data_ok_i = 1'b0;
    logic [31:0] bus_rdata_i = 32'h0;

    dmem_bridge #(.MAP_KSEG(1'b1)) u_dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .mem_en_i     (mem_en_i),
        .mem_wen_i    (mem_wen_i),
        .mem_size_i   (mem_size_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_cancel_i (mem_cancel_i),
        .pipe_stall_i (pipe_stall_i),
        .mem_rdata_o  (mem_rdata_o),
        .mem_stall_o  (mem_stall_o),
        .bus_req_o    (bus_req_o),
        .bus_wr_o     (bus_wr_o),
        .bus_size_o   (bus_size_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_addr_ok_i(bus_addr_ok_i),
        .bus_data_ok_i(bus_data_ok_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] addr;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] wdata;
    } bus_t;

    bus_t        exp_bus[$];
    logic [31:0] exp_rd[$];
    logic [31:0] last_rd = 32'h0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    // Bus monitor: a fresh request must match the queue head, a held one must not move.
    bus_t held;
    bus_t mon_e;
    logic req_seen = 1'b0;
    always @(negedge clk_i) begin
        if (bus_req_o) begin
            if (!req_seen) begin
                check_eq("bus_expected", 32'(exp_bus.size() != 0), 32'd1);
                if (exp_bus.size() != 0) begin
                    mon_e = exp_bus.pop_front();
                    check_eq("bus_addr", bus_addr_o, mon_e.addr);
                    check_eq("bus_wr", 32'(bus_wr_o), 32'(mon_e.wr));
                    check_eq("bus_size", 32'(bus_size_o), 32'(mon_e.size));
                    check_eq("bus_wdata", bus_wdata_o, mon_e.wdata);
                end
            end else begin
                check_eq("bus_addr_stable", bus_addr_o, held.addr);
                check_eq("bus_wr_stable", 32'(bus_wr_o), 32'(held.wr));
                check_eq("bus_size_stable", 32'(bus_size_o), 32'(held.size));
                check_eq("bus_wdata_stable", bus_wdata_o, held.wdata);
            end
        end
        req_seen <= bus_req_o;
        held     <= '{bus_addr_o, bus_wr_o, bus_size_o, bus_wdata_o};
    end

    // One complete access from issue (IDLE) to retirement; leaves the FSM idle.
    task automatic do_access(input logic [31:0] addr, input logic [31:0] exp_addr,
                             input logic [3:0] wen, input logic [1:0] size,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int addr_dly, input int data_dly, input int pstall);
        logic [31:0] exp;
        mem_en_i     = 1'b1;
        mem_wen_i    = wen;
        mem_size_i   = size;
        mem_addr_i   = addr;
        mem_wdata_i  = wdata;
        mem_cancel_i = 1'b0;
        pipe_stall_i = 1'b0;
        exp_bus.push_back('{exp_addr, |wen, size, wdata});
        sample();
        check_eq("issue_rdata", mem_rdata_o, last_rd);
        check_eq("issue_stall", 32'(mem_stall_o), 32'd1);
        check_eq("issue_noreq", 32'(bus_req_o), 32'd0);
        if (wen == 4'h0) last_rd = rdata;
        exp_rd.push_back(last_rd);
        step();
        for (int i = 0; i <= addr_dly; i++) begin
            bus_addr_ok_i = (i == addr_dly);
            sample();
            check_eq("req_active", 32'(bus_req_o), 32'd1);
            check_eq("req_stall", 32'(mem_stall_o), 32'd1);
            step();
        end
        bus_addr_ok_i = 1'b0;
        for (int j = 0; j <= data_dly; j++) begin
            bus_data_ok_i = (j == data_dly);
            bus_rdata_i   = (j == data_dly) ? rdata : 32'h5A5A_5A5A;
            sample();
            check_eq("wait_noreq", 32'(bus_req_o), 32'd0);
            check_eq("wait_stall", 32'(mem_stall_o), 32'd1);
            step();
        end
        bus_data_ok_i = 1'b0;
        bus_rdata_i   = 32'hA5A5_A5A5;
        exp = exp_rd.pop_front();
        for (int k = 0; k <= pstall; k++) begin
            pipe_stall_i = (k < pstall);
            sample();
            check_eq("done_stall", 32'(mem_stall_o), 32'd0);
            check_eq("done_noreq", 32'(bus_req_o), 32'd0);
            check_eq("done_rdata", mem_rdata_o, exp);
            step();
        end
        mem_en_i     = 1'b0;
        pipe_stall_i = 1'b0;
        sample();
        check_eq("idle_noreq", 32'(bus_req_o), 32'd0);
        check_eq("idle_rdata", mem_rdata_o, exp);
        step();
    endtask

    initial begin
        // Reset state with a pending request: nothing may leak out.
        mem_en_i = 1'b1;
        #3;
        check_eq("rst_stall", 32'(mem_stall_o), 32'd0);
        check_eq("rst_req", 32'(bus_req_o), 32'd0);
        check_eq("rst_addr", bus_addr_o, 32'h0);
        check_eq("rst_rdata", mem_rdata_o, 32'h0);
        #9;
        mem_en_i = 1'b0;
        rst_ni   = 1'b1;
        step();

        // Minimum-latency kseg1 word load.
        do_access(32'hBFC0_0100, 32'h1FC0_0100, 4'b0000, 2'd2, 32'h0, 32'h1234_5678, 0, 0, 0);
        // kseg0 byte store with a slow address phase; rdata must not change.
        do_access(32'h8000_0011, 32'h0000_0011, 4'b0010, 2'd0, 32'h0000_AB00, 32'hFFFF_FFFF,
                  4, 0, 0);
        // Load retired while the pipeline is stalled elsewhere.
        do_access(32'h0000_2000, 32'h0000_2000, 4'b0000, 2'd2, 32'h0, 32'h0BAD_F00D, 0, 1, 3);
        // Unmapped kseg2 store and kseg1 halfword load.
        do_access(32'hC000_0004, 32'hC000_0004, 4'b1111, 2'd2, 32'h7654_3210, 32'h0, 1, 2, 0);
        do_access(32'hA000_0042, 32'h0000_0042, 4'b0000, 2'd1, 32'h0, 32'h0000_BEEF, 0, 0, 0);

        // Cancel in IDLE suppresses the request.
        mem_en_i     = 1'b1;
        mem_cancel_i = 1'b1;
        mem_addr_i   = 32'h0000_0500;
        for (int c = 0; c < 2; c++) begin
            sample();
            check_eq("cancel_idle_req", 32'(bus_req_o), 32'd0);
            check_eq("cancel_idle_stall", 32'(mem_stall_o), 32'd0);
            step();
        end

        // Cancel in REQ before addr_ok drops the request next cycle.
        mem_cancel_i = 1'b0;
        mem_wen_i    = 4'b0000;
        mem_size_i   = 2'd2;
        mem_addr_i   = 32'h8000_0100;
        mem_wdata_i  = 32'h0;
        exp_bus.push_back('{32'h0000_0100, 1'b0, 2'd2, 32'h0});
        sample();
        step();
        mem_cancel_i = 1'b1;
        sample();
        check_eq("cancel_req_active", 32'(bus_req_o), 32'd1);
        check_eq("cancel_req_stall", 32'(mem_stall_o), 32'd0);
        step();
        mem_cancel_i = 1'b0;
        mem_en_i     = 1'b0;
        sample();
        check_eq("cancel_req_dropped", 32'(bus_req_o), 32'd0);
        step();

        // Cancel in WAIT: the data phase is drained and the next load waits for it.
        mem_en_i    = 1'b1;
        mem_addr_i  = 32'h0000_3000;
        exp_bus.push_back('{32'h0000_3000, 1'b0, 2'd2, 32'h0});
        sample();
        step();
        bus_addr_ok_i = 1'b1;
        sample();
        step();
        bus_addr_ok_i = 1'b0;
        mem_cancel_i  = 1'b1;
        sample();
        check_eq("cancel_wait_stall", 32'(mem_stall_o), 32'd0);
        step();
        mem_cancel_i = 1'b0;
        mem_addr_i   = 32'h0000_4000;
        sample();
        check_eq("discard_stall", 32'(mem_stall_o), 32'd1);
        check_eq("discard_noreq", 32'(bus_req_o), 32'd0);
        step();
        step();
        bus_data_ok_i = 1'b1;
        bus_rdata_i   = 32'hDEAD_BEEF;
        sample();
        check_eq("discard_data_noreq", 32'(bus_req_o), 32'd0);
        check_eq("discard_data_stall", 32'(mem_stall_o), 32'd1);
        step();
        bus_data_ok_i = 1'b0;
        do_access(32'h0000_4000, 32'h0000_4000, 4'b0000, 2'd2, 32'h0, 32'hCAFE_F00D, 0, 0, 0);

        // Asynchronous reset in the middle of a store's address phase.
        mem_en_i    = 1'b1;
        mem_wen_i   = 4'b1111;
        mem_size_i  = 2'd2;
        mem_addr_i  = 32'h8000_0200;
        mem_wdata_i = 32'h1122_3344;
        exp_bus.push_back('{32'h0000_0200, 1'b1, 2'd2, 32'h1122_3344});
        sample();
        step();
        sample();
        check_eq("prerst_req", 32'(bus_req_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check_eq("arst_req", 32'(bus_req_o), 32'd0);
        check_eq("arst_wr", 32'(bus_wr_o), 32'd0);
        check_eq("arst_size", 32'(bus_size_o), 32'd0);
        check_eq("arst_addr", bus_addr_o, 32'h0);
        check_eq("arst_wdata", bus_wdata_o, 32'h0);
        check_eq("arst_rdata", mem_rdata_o, 32'h0);
        check_eq("arst_stall", 32'(mem_stall_o), 32'd0);
        last_rd = 32'h0;
        step();
        mem_en_i = 1'b0;
        sample();
        #2;
        rst_ni = 1'b1;
        step();
        do_access(32'h0000_0800, 32'h0000_0800, 4'b0000, 2'd2, 32'h0, 32'h600D_CAFE, 1, 1, 0);

        check_eq("bus_q_drained", 32'(exp_bus.size()), 32'd0);
        check_eq("rd_q_drained", 32'(exp_rd.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
